// File: rtl/dispatch_queue_pkg.sv
// Shared dispatch definitions: packet layouts, machine widths and the default
// queue geometry used by the decode-to-RS dispatch stage.
package dispatch_queue_pkg;

    localparam int DP_WIDTH       = 3;
    localparam int DP_QUEUE_DEPTH = 8;
    localparam int RSLEN          = 16;
    localparam int ROBLEN         = 32;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } DP_IS_PACKET;

    typedef struct packed {
        logic [$clog2(RSLEN+1)-1:0] free_cnt;
    } RS_DP_PACKET;

endpackage

// File: rtl/dispatch_queue_lane_count.sv
// dp_lane_count: number of contiguous set bits starting at bit 0; a set bit
// above the first clear bit does not count.
module dp_lane_count #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0]           valid,
    output logic [$clog2(WIDTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(WIDTH+1);

    logic run;

    always_comb begin
        count = '0;
        run   = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
            run = run & valid[k];
            if (run) count = count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// Circular dispatch buffer between decode and the reservation station.
// Define DP_BYPASS_EN to let lanes arriving at an empty queue dispatch in the same cycle.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int WIDTH = DP_WIDTH,
    parameter int DEPTH = DP_QUEUE_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash_flag,
    input  logic [WIDTH-1:0]              if_valid,
    input  DP_IS_PACKET [WIDTH-1:0]       if_packet,
    output logic                          if_ready,
    input  logic [$clog2(RSLEN+1)-1:0]    rs_free_cnt,
    input  logic [$clog2(ROBLEN+1)-1:0]   rob_free_cnt,
    output DP_IS_PACKET [WIDTH-1:0]       dp_packet_out,
    output logic [$clog2(WIDTH+1)-1:0]    dp_count,
    output logic                          dp_stall
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int CNT_W = $clog2(WIDTH+1);

    DP_IS_PACKET       entries [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [OCC_W-1:0]  occ, occ_next;
    logic [CNT_W-1:0]  n_in, skip, enq_n, deq;
    logic [31:0]       avail;
    logic              enq, byp;

    function automatic logic [31:0] min2(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

    dp_lane_count #(.WIDTH(WIDTH)) u_lane_count (
        .valid (if_valid),
        .count (n_in)
    );

    always_comb begin
        enq = if_ready && (n_in != '0) && !squash_flag;
`ifdef DP_BYPASS_EN
        byp = enq && (occ == '0);
`else
        byp = 1'b0;
`endif
        avail = 32'(occ) + (byp ? 32'(n_in) : 32'd0);

        dp_count = '0;
        if (!squash_flag)
            dp_count = CNT_W'(min2(min2(avail, 32'(WIDTH)),
                                   min2(32'(rs_free_cnt), 32'(rob_free_cnt))));

        // Bypassed lanes leave straight from decode; the rest of the group is queued.
        skip     = byp ? dp_count : '0;
        deq      = byp ? '0 : dp_count;
        enq_n    = enq ? (n_in - skip) : '0;
        occ_next = occ + OCC_W'(enq_n) - OCC_W'(deq);

        for (int k = 0; k < WIDTH; k++) begin
            dp_packet_out[k] = entries[head + PTR_W'(k)];
            if (byp) dp_packet_out[k] = if_packet[k];
            dp_packet_out[k].valid = (k < int'(dp_count));
        end

        dp_stall = (occ != '0) && (dp_count == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            if_ready <= 1'b1;
        end else if (squash_flag) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            if_ready <= 1'b1;
        end else begin
            head     <= head + PTR_W'(deq);
            tail     <= tail + PTR_W'(enq_n);
            occ      <= occ_next;
            if_ready <= (DEPTH - int'(occ_next)) >= WIDTH;
        end
    end

    // Entry storage carries data only, so it is left out of reset.
    always_ff @(posedge clock) begin
        for (int k = 0; k < WIDTH; k++) begin
            if (enq && (k >= int'(skip)) && (k < int'(n_in)))
                entries[tail + PTR_W'(k - int'(skip))] <= if_packet[k];
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// Scoreboard bench for dispatch_queue: accepted instructions are queued in
// program order and a negedge monitor checks every dispatched lane against them.
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    logic              clock;
    logic              reset;
    logic              squash_flag;
    logic [2:0]        if_valid;
    DP_IS_PACKET [2:0] if_packet;
    logic              if_ready;
    logic [4:0]        rs_free_cnt;
    logic [5:0]        rob_free_cnt;
    DP_IS_PACKET [2:0] dp_packet_out;
    logic [1:0]        dp_count;
    logic              dp_stall;

    int tests;
    int fails;
    int exp_q[$];

    dispatch_queue #(.WIDTH(3), .DEPTH(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .squash_flag   (squash_flag),
        .if_valid      (if_valid),
        .if_packet     (if_packet),
        .if_ready      (if_ready),
        .rs_free_cnt   (rs_free_cnt),
        .rob_free_cnt  (rob_free_cnt),
        .dp_packet_out (dp_packet_out),
        .dp_count      (dp_count),
        .dp_stall      (dp_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every valid lane must be the next-oldest accepted instruction.
    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            chk("lane_valid_shape", int'(dp_packet_out[k].valid), int'(k < int'(dp_count)));
            if (dp_packet_out[k].valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_dispatch lane %0d: got inst %0d, expected nothing", k,
                             dp_packet_out[k].inst);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (int'(dp_packet_out[k].inst) != e) begin
                        fails++;
                        $display("FAIL dispatch_order lane %0d: got inst %0d, expected %0d", k,
                                 dp_packet_out[k].inst, e);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [2:0] v, input int id0, input int rs, input int rob,
                         input logic sq);
        if_valid     = v;
        squash_flag  = sq;
        rs_free_cnt  = 5'(rs);
        rob_free_cnt = 6'(rob);
        for (int k = 0; k < 3; k++) begin
            if_packet[k].valid = v[k];
            if_packet[k].pc    = 32'(k * 4);
            if_packet[k].inst  = 32'(id0 + k);
        end
        @(negedge clock);
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic push3(input int id0);
        exp_q.push_back(id0);
        exp_q.push_back(id0 + 1);
        exp_q.push_back(id0 + 2);
    endtask

    initial begin
        int byp_a, byp_b;
        tests = 0;
        fails = 0;
`ifdef DP_BYPASS_EN
        byp_a = 3; byp_b = 0;
`else
        byp_a = 0; byp_b = 3;
`endif
        reset = 1'b0;
        drive(3'b000, 0, 0, 0, 1'b0);
        chk("reset_if_ready", int'(if_ready), 1);
        chk("reset_dp_count", int'(dp_count), 0);
        chk("reset_dp_stall", int'(dp_stall), 0);
        reset = 1'b1;
        adv();

        // Three lanes A,B,C with plenty of RS/ROB room.
        push3(100);
        drive(3'b111, 100, 8, 8, 1'b0);
        chk("abc_accept_count", int'(dp_count), byp_a);
        chk("abc_accept_ready", int'(if_ready), 1);
        adv();
        drive(3'b000, 0, 8, 8, 1'b0);
        chk("abc_dispatch_count", int'(dp_count), byp_b);
        adv();
        drive(3'b000, 0, 8, 8, 1'b0);
        chk("abc_drained_count", int'(dp_count), 0);
        chk("abc_drained_stall", int'(dp_stall), 0);
        adv();

        // Fill to 8 with the RS full.
        push3(10);
        drive(3'b111, 10, 0, 8, 1'b0);
        chk("fill1_count", int'(dp_count), 0);
        adv();
        exp_q.push_back(13);
        exp_q.push_back(14);
        drive(3'b011, 13, 0, 8, 1'b0);
        chk("fill2_ready_occ3", int'(if_ready), 1);
        chk("fill2_stall", int'(dp_stall), 1);
        adv();
        push3(15);
        drive(3'b111, 15, 0, 8, 1'b0);
        chk("fill3_ready_occ5", int'(if_ready), 1);
        adv();
        drive(3'b111, 90, 0, 8, 1'b0);
        chk("full_ready", int'(if_ready), 0);
        chk("full_stall", int'(dp_stall), 1);
        chk("full_count", int'(dp_count), 0);
        adv();

        // Drain 3, then RS/ROB limited dispatch at occ=5.
        drive(3'b000, 0, 3, 8, 1'b0);
        chk("drain3_count", int'(dp_count), 3);
        chk("drain3_ready_occ8", int'(if_ready), 0);
        adv();
        drive(3'b000, 0, 2, 1, 1'b0);
        chk("rob_limit_count", int'(dp_count), 1);
        chk("rob_limit_lane0", int'(dp_packet_out[0].inst), 13);
        chk("occ5_ready", int'(if_ready), 1);
        adv();
        drive(3'b000, 0, 1, 8, 1'b0);
        chk("second_oldest_lane0", int'(dp_packet_out[0].inst), 14);
        adv();

        // Non-contiguous valid: only lane 0 is taken.
        exp_q.push_back(20);
        drive(3'b101, 20, 0, 8, 1'b0);
        chk("gap_stall", int'(dp_stall), 1);
        adv();
        drive(3'b000, 0, 8, 8, 1'b0);
        chk("gap_drain_count", int'(dp_count), 3);
        adv();
        drive(3'b000, 0, 8, 8, 1'b0);
        chk("gap_only_lane0", int'(dp_count), 1);
        chk("gap_lane0_inst", int'(dp_packet_out[0].inst), 20);
        adv();
        drive(3'b000, 0, 8, 8, 1'b0);
        chk("gap_empty_count", int'(dp_count), 0);
        adv();

        // Build occ=6, then squash.
        push3(23);
        drive(3'b111, 23, 0, 8, 1'b0);
        adv();
        push3(26);
        drive(3'b111, 26, 0, 8, 1'b0);
        adv();
        drive(3'b111, 30, 8, 8, 1'b1);
        chk("squash_count", int'(dp_count), 0);
        chk("squash_ready_occ6", int'(if_ready), 0);
        adv();
        exp_q.delete();

        // Post-squash refill; wrap head to 6 then enqueue into slots 6,7,0.
        push3(40);
        drive(3'b111, 40, 0, 8, 1'b0);
        chk("post_squash_ready", int'(if_ready), 1);
        chk("post_squash_count", int'(dp_count), 0);
        chk("post_squash_stall", int'(dp_stall), 0);
        adv();
        push3(43);
        drive(3'b111, 43, 0, 8, 1'b0);
        adv();
        drive(3'b000, 0, 8, 8, 1'b0);
        chk("wrap_pre1_count", int'(dp_count), 3);
        adv();
        drive(3'b000, 0, 8, 8, 1'b0);
        chk("wrap_pre2_count", int'(dp_count), 3);
        adv();
        push3(50);
        drive(3'b111, 50, 0, 8, 1'b0);
        chk("wrap_enq_count", int'(dp_count), 0);
        adv();
        drive(3'b000, 0, 8, 8, 1'b0);
        chk("wrap_count", int'(dp_count), 3);
        chk("wrap_lane0", int'(dp_packet_out[0].inst), 50);
        chk("wrap_lane1", int'(dp_packet_out[1].inst), 51);
        chk("wrap_lane2", int'(dp_packet_out[2].inst), 52);
        adv();
        drive(3'b000, 0, 8, 8, 1'b0);
        chk("end_count", int'(dp_count), 0);
        chk("end_ready", int'(if_ready), 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
